// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Segment patterns, select codes and decode types shared by the
//               seven-segment bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Active-low segment patterns on D[7:1] = a..g
    localparam logic [6:0] SS_0     = 7'b0000001;
    localparam logic [6:0] SS_1     = 7'b1001111;
    localparam logic [6:0] SS_2     = 7'b0010010;
    localparam logic [6:0] SS_3     = 7'b0000110;
    localparam logic [6:0] SS_4     = 7'b1001100;
    localparam logic [6:0] SS_5     = 7'b0100100;
    localparam logic [6:0] SS_6     = 7'b0100000;
    localparam logic [6:0] SS_7     = 7'b0001101;
    localparam logic [6:0] SS_8     = 7'b0000000;
    localparam logic [6:0] SS_9     = 7'b0000100;
    localparam logic [6:0] SS_A     = 7'b0001000;
    localparam logic [6:0] SS_B     = 7'b1100000;
    localparam logic [6:0] SS_C     = 7'b0110001;
    localparam logic [6:0] SS_D     = 7'b1000010;
    localparam logic [6:0] SS_E     = 7'b0110000;
    localparam logic [6:0] SS_F     = 7'b0111000;
    localparam logic [6:0] SS_BLANK = 7'b1111111;

    localparam logic [3:0] SEL_IDLE = 4'b1111;
    localparam logic [3:0] SEL_ALL  = 4'b0000;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } hex_dec_t;

    typedef enum logic [1:0] {
        SK_IDLE   = 2'd0,
        SK_SINGLE = 2'd1,
        SK_ALL    = 2'd2,
        SK_BAD    = 2'd3
    } sel_kind_t;

    function automatic sel_kind_t classify_sel(input logic [3:0] sel);
        sel_kind_t kind;
        case (sel)
            SEL_IDLE:                          kind = SK_IDLE;
            SEL_ALL:                           kind = SK_ALL;
            4'b1110, 4'b1101, 4'b1011, 4'b0111: kind = SK_SINGLE;
            default:                           kind = SK_BAD;
        endcase
        return kind;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_bus_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ssd_bus_decoder_if
// Description : Sampled SSD bus plus decoded readback outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface ssd_bus_decoder_if;

    logic [7:0]  D;
    logic [3:0]  ssd_active;
    logic        clr;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [3:0]  dp;
    logic        err;
    logic        err_sticky;
    logic        frame_done;

    modport slave (
        input  D, ssd_active, clr,
        output value, digit_valid, dp, err, err_sticky, frame_done
    );

    modport master (
        output D, ssd_active, clr,
        input  value, digit_valid, dp, err, err_sticky, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/ssd_pattern_to_hex.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pattern_to_hex
// Description : Combinational active-low 7-segment pattern to hex nibble.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_pattern_to_hex
    import ssd_pkg::*;
(
    input  logic [6:0] i_pattern,
    output hex_dec_t   o_dec
);

    always_comb begin
        o_dec = '{legal: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (i_pattern)
            SS_0:     o_dec.nibble = 4'h0;
            SS_1:     o_dec.nibble = 4'h1;
            SS_2:     o_dec.nibble = 4'h2;
            SS_3:     o_dec.nibble = 4'h3;
            SS_4:     o_dec.nibble = 4'h4;
            SS_5:     o_dec.nibble = 4'h5;
            SS_6:     o_dec.nibble = 4'h6;
            SS_7:     o_dec.nibble = 4'h7;
            SS_8:     o_dec.nibble = 4'h8;
            SS_9:     o_dec.nibble = 4'h9;
            SS_A:     o_dec.nibble = 4'hA;
            SS_B:     o_dec.nibble = 4'hB;
            SS_C:     o_dec.nibble = 4'hC;
            SS_D:     o_dec.nibble = 4'hD;
            SS_E:     o_dec.nibble = 4'hE;
            SS_F:     o_dec.nibble = 4'hF;
            SS_BLANK: begin
                o_dec.legal = 1'b0;
                o_dec.blank = 1'b1;
            end
            default:  o_dec.legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ssd_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ssd_bus_decoder
// Description : Readback monitor turning a sampled SSD bus into hex digits.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_bus_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ssd_bus_decoder_if.slave bus
);
    import ssd_pkg::*;

    localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

    logic [11:0] r_prev;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [11:0] w_sample;
    logic        w_capture;
    sel_kind_t   w_kind;
    logic [3:0]  w_target;
    logic [3:0]  w_write;
    hex_dec_t    w_dec;
    logic        w_err_next;
    logic [3:0]  w_mask_acc;
    logic        w_frame_next;

    logic [15:0] r_value, w_value_next;
    logic [3:0]  r_valid, w_valid_next;
    logic [3:0]  r_dp,    w_dp_next;
    logic [3:0]  r_mask;
    logic        r_err;
    logic        r_sticky;
    logic        r_frame;

    assign w_sample = {bus.D, bus.ssd_active};

    always_comb begin
        w_cnt_next = r_cnt;
        if (bus.ssd_active == SEL_IDLE)
            w_cnt_next = 4'd0;
        else if (w_sample != r_prev)
            w_cnt_next = 4'd1;
        else if (r_cnt < c_stable)
            w_cnt_next = r_cnt + 4'd1;
    end

    // Only the edge that reaches the threshold captures, so a long dwell yields one capture
    assign w_capture = (w_cnt_next == c_stable) && (r_cnt != c_stable);

    assign w_kind = classify_sel(bus.ssd_active);

    always_comb begin
        w_target = 4'h0;
        case (w_kind)
            SK_SINGLE: w_target = ~bus.ssd_active;
            SK_ALL:    w_target = 4'hF;
            default:   w_target = 4'h0;
        endcase
    end

    assign w_write = w_capture ? w_target : 4'h0;

    ssd_pattern_to_hex u_pattern_to_hex (
        .i_pattern (bus.D[7:1]),
        .o_dec     (w_dec)
    );

    assign w_err_next = w_capture &&
                        ((w_kind == SK_BAD) ||
                         ((w_target != 4'h0) && !w_dec.legal && !w_dec.blank));

    always_comb begin
        w_value_next = r_value;
        w_valid_next = r_valid;
        w_dp_next    = r_dp;
        for (int k = 0; k < 4; k++) begin
            if (w_write[k]) begin
                if (w_dec.legal) begin
                    w_value_next[4*k +: 4] = w_dec.nibble;
                    w_valid_next[k]        = 1'b1;
                    w_dp_next[k]           = ~bus.D[0];
                end else if (w_dec.blank) begin
                    w_value_next[4*k +: 4] = 4'h0;
                    w_valid_next[k]        = 1'b0;
                    w_dp_next[k]           = ~bus.D[0];
                end else begin
                    w_valid_next[k]        = 1'b0;
                end
            end
        end
    end

    // clr empties the mask first so a same-cycle capture still counts toward the next frame
    assign w_mask_acc   = (bus.clr ? 4'h0 : r_mask) | w_write;
    assign w_frame_next = &w_mask_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= 12'h000;
            r_cnt    <= 4'd0;
            r_value  <= 16'h0000;
            r_valid  <= 4'h0;
            r_dp     <= 4'h0;
            r_mask   <= 4'h0;
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_prev   <= w_sample;
            r_cnt    <= w_cnt_next;
            r_value  <= w_value_next;
            r_valid  <= w_valid_next;
            r_dp     <= w_dp_next;
            r_mask   <= w_frame_next ? 4'h0 : w_mask_acc;
            r_err    <= w_err_next;
            r_sticky <= w_err_next | (r_sticky & ~bus.clr);
            r_frame  <= w_frame_next;
        end
    end

    assign bus.value       = r_value;
    assign bus.digit_valid = r_valid;
    assign bus.dp          = r_dp;
    assign bus.err         = r_err;
    assign bus.err_sticky  = r_sticky;
    assign bus.frame_done  = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_ssd_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_bus_decoder
// Description : Directed and randomized checks of ssd_bus_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_bus_decoder;

    localparam int STABLE = 4;

    logic clk;
    logic rst_n;

    ssd_bus_decoder_if bus ();

    ssd_bus_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference state: digits as arrays, dwell as an unbounded run length
    int         m_nib [4];
    bit         m_vld [4];
    bit         m_dp  [4];
    bit         m_err, m_sticky, m_frame;
    bit [3:0]   m_seen;
    int         m_run;
    logic [11:0] m_prev;
    bit         m_have_prev;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_pat(input logic [6:0] p);
        if (p == 7'h7F) return 16;
        for (int i = 0; i < 16; i++)
            if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_nib[k] = 0; m_vld[k] = 0; m_dp[k] = 0;
        end
        m_err = 0; m_sticky = 0; m_frame = 0; m_seen = 0;
        m_run = 0; m_have_prev = 0; m_prev = '0;
    endtask

    task automatic model_step(input logic [7:0] d, input logic [3:0] sel, input logic c);
        logic [11:0] s;
        int zeros, pi;
        bit [3:0] tgt;
        s = {d, sel};
        if (sel == 4'hF)                       m_run = 0;
        else if (m_have_prev && s == m_prev)   m_run++;
        else                                   m_run = 1;
        m_prev = s; m_have_prev = 1;
        m_err = 0; m_frame = 0;
        if (c) m_seen = 0;
        if (m_run == STABLE) begin
            zeros = 0;
            for (int k = 0; k < 4; k++) if (!sel[k]) zeros++;
            tgt = 0;
            if (zeros == 1)      tgt = ~sel;
            else if (zeros == 4) tgt = 4'hF;
            else                 m_err = 1;
            pi = find_pat(d[7:1]);
            for (int k = 0; k < 4; k++) begin
                if (tgt[k]) begin
                    m_seen[k] = 1;
                    if (pi >= 0 && pi < 16) begin
                        m_nib[k] = pi; m_vld[k] = 1; m_dp[k] = ~d[0];
                    end else if (pi == 16) begin
                        m_nib[k] = 0; m_vld[k] = 0; m_dp[k] = ~d[0];
                    end else begin
                        m_vld[k] = 0; m_err = 1;
                    end
                end
            end
        end
        if (m_err)  m_sticky = 1;
        else if (c) m_sticky = 0;
        if (m_seen == 4'hF) begin
            m_frame = 1; m_seen = 0;
        end
    endtask

    always @(posedge clk) begin
        logic [15:0] ev;
        logic [3:0]  evl, edp;
        if (!rst_n) model_reset();
        else        model_step(bus.D, bus.ssd_active, bus.clr);
        #1;
        for (int k = 0; k < 4; k++) begin
            ev[4*k +: 4] = 4'(m_nib[k]);
            evl[k] = m_vld[k];
            edp[k] = m_dp[k];
        end
        check("value",       bus.value,               ev);
        check("digit_valid", {12'h0, bus.digit_valid}, {12'h0, evl});
        check("dp",          {12'h0, bus.dp},          {12'h0, edp});
        check("err",         {15'h0, bus.err},         {15'h0, m_err});
        check("err_sticky",  {15'h0, bus.err_sticky},  {15'h0, m_sticky});
        check("frame_done",  {15'h0, bus.frame_done},  {15'h0, m_frame});
    end

    task automatic hold(input logic [7:0] d, input logic [3:0] sel, input int n);
        bus.D = d;
        bus.ssd_active = sel;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, bus.value, 16'h0);
        check({tag, "_valid"}, {12'h0, bus.digit_valid}, 16'h0);
        check({tag, "_dp"},    {12'h0, bus.dp}, 16'h0);
        check({tag, "_flags"}, {13'h0, bus.err, bus.err_sticky, bus.frame_done}, 16'h0);
    endtask

    initial begin
        logic [7:0] d;
        logic [3:0] sel;
        int n;
        rst_n = 1'b0;
        bus.D = 8'hFF;
        bus.ssd_active = 4'hF;
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        hold(8'hFF, 4'hF, 2);

        // Single digit capture latency
        hold(8'h0D, 4'b1110, 3);
        check("t1_pre_valid", {12'h0, bus.digit_valid}, 16'h0);
        hold(8'h0D, 4'b1110, 1);
        check("t1_value", {12'h0, bus.value[3:0]}, 16'h3);
        check("t1_valid", {12'h0, bus.digit_valid}, 16'h1);
        check("t1_dp",    {12'h0, bus.dp}, 16'h0);
        hold(8'h0D, 4'b1110, 2);

        // Scan 1,2,A,F across digits 0..3
        hold(8'h9F, 4'b1110, 8);
        hold(8'h25, 4'b1101, 8);
        hold(8'h11, 4'b1011, 8);
        hold(8'h71, 4'b0111, 4);
        check("t2_frame", {15'h0, bus.frame_done}, 16'h1);
        hold(8'h71, 4'b0111, 4);
        check("t2_value", bus.value, 16'hFA21);
        check("t2_valid", {12'h0, bus.digit_valid}, 16'hF);

        // Broadcast E with dp lit
        hold(8'h60, 4'b0000, 4);
        check("t3_value", bus.value, 16'hEEEE);
        check("t3_dp",    {12'h0, bus.dp}, 16'hF);
        check("t3_frame", {15'h0, bus.frame_done}, 16'h1);
        hold(8'h60, 4'b0000, 3);

        // Glitch rejection then illegal pattern on digit 1
        hold(8'h25, 4'b1101, 6);
        hold(8'hFE, 4'b1101, 3);
        hold(8'h25, 4'b1101, 6);
        check("t4_sticky", {15'h0, bus.err_sticky}, 16'h0);
        check("t4_nib1",   {12'h0, bus.value[7:4]}, 16'h2);
        check("t4_dp1",    {15'h0, bus.dp[1]}, 16'h0);
        hold(8'hAA, 4'b1101, 4);
        check("t4_err",    {15'h0, bus.err}, 16'h1);
        check("t4_sticky2", {15'h0, bus.err_sticky}, 16'h1);
        check("t4_valid1", {15'h0, bus.digit_valid[1]}, 16'h0);
        hold(8'hAA, 4'b1101, 2);

        // Illegal select, then clr alone, then clr together with a new error
        hold(8'h25, 4'b1100, 4);
        check("t5_err",   {15'h0, bus.err}, 16'h1);
        check("t5_valid", {12'h0, bus.digit_valid}, 16'hD);
        hold(8'h25, 4'b1100, 2);
        bus.clr = 1'b1;
        hold(8'h25, 4'b1100, 1);
        bus.clr = 1'b0;
        check("t5_clr", {15'h0, bus.err_sticky}, 16'h0);
        hold(8'h9F, 4'b1010, 3);
        bus.clr = 1'b1;
        hold(8'h9F, 4'b1010, 1);
        bus.clr = 1'b0;
        check("t5_err2",    {15'h0, bus.err}, 16'h1);
        check("t5_sticky2", {15'h0, bus.err_sticky}, 16'h1);
        hold(8'h9F, 4'b1010, 2);

        // Reset during the third cycle of a dwell
        hold(8'h0D, 4'b1110, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        hold(8'h0D, 4'b1110, 3);
        check("t6_pre_valid", {12'h0, bus.digit_valid}, 16'h0);
        hold(8'h0D, 4'b1110, 1);
        check("t6_valid", {12'h0, bus.digit_valid}, 16'h1);
        check("t6_value", bus.value, 16'h0003);

        // Randomized dwells, glitches, selects and clears
        for (int t = 0; t < 120; t++) begin
            case ($urandom % 8)
                0, 1, 2, 3: sel = ~(4'b0001 << ($urandom % 4));
                4:          sel = 4'b0000;
                5:          sel = 4'b1111;
                default:    sel = 4'($urandom);
            endcase
            case ($urandom % 4)
                0, 1:    d = {seg_tab[$urandom % 16], 1'($urandom)};
                2:       d = {7'h7F, 1'($urandom)};
                default: d = 8'($urandom);
            endcase
            n = $urandom_range(1, 8);
            bus.D = d;
            bus.ssd_active = sel;
            for (int c = 0; c < n; c++) begin
                bus.clr = ($urandom % 16 == 0);
                @(negedge clk);
            end
            bus.clr = 1'b0;
        end
        hold(8'hFF, 4'hF, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_bus_decoder.md
# ssd_bus_decoder

Receive-side counterpart of the team's seven-segment drivers. The block samples the active-low segment bus (`D`) and the active-low digit-enable bus (`ssd_active`) and converts the segment patterns back into hex nibbles, one per digit position. Each digit position also gets a valid flag and a decimal-point flag. It sits beside any SSD driver as a self-check/readback monitor, and feeds lab benches and on-chip comparison logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is captured; legal range 1..15.
- `clk`  input  1  system clock; all state on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `D`  input  8  segment bus, active-low. Bit 7..1 = segments a..g, bit 0 = dp.
- `ssd_active`  input  4  digit enables, active-low; bit k selects digit k.
- `clr`  input  1  synchronous clear of `err_sticky` and the frame mask.
- `value`  output  16  decoded nibbles; `value[4k+3:4k]` = digit k.
- `digit_valid`  output  4  bit k = 1 when digit k holds a legal hex pattern.
- `dp`  output  4  bit k = 1 when digit k's decimal point was lit.
- `err`  output  1  one-cycle pulse on an illegal pattern or illegal select at capture.
- `err_sticky`  output  1  set by `err`, cleared by `clr`.
- `frame_done`  output  1  one-cycle pulse when all four digits have been captured since the last pulse, reset or `clr`.

## Operation
- Reset values: `value` = 0, `digit_valid` = 0, `dp` = 0, `err` = 0, `err_sticky` = 0, `frame_done` = 0, stability counter = 0, frame mask = 0.
- Sample register: `{D, ssd_active}` is registered every cycle as `prev`.
- Stability counter `cnt` (4 bits, saturating at `STABLE_CYCLES`):
  - If the current input differs from `prev`, `cnt` loads 1.
  - Otherwise `cnt` increments up to `STABLE_CYCLES`, then holds.
  - `ssd_active` = 4'b1111 (idle) forces `cnt` to 0; no capture is made while idle.
- Capture fires on the cycle `cnt` transitions to `STABLE_CYCLES`. There is exactly one capture per stable dwell.
- Select decode at capture:
  - One-cold select: target is digit k.
  - 4'b0000: broadcast; all four digits are written with the same result.
  - Any other multi-zero code: illegal select. `err` pulses; no digit is written.
- Pattern decode (on `D[7:1]`):
  - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110
  - 4: 1001100, 5: 0100100, 6: 0100000, 7: 0001101
  - 8: 0000000, 9: 0000100, A: 0001000, b: 1100000
  - C: 0110001, d: 1000010, E: 0110000, F: 0111000
- Write results per target digit:
  - Legal pattern: nibble written, `digit_valid` = 1, `dp` = ~`D[0]`.
  - Blank pattern (1111111): `value` nibble = 0, `digit_valid` = 0, `dp` = ~`D[0]`; not an error.
  - Any other pattern: `err` pulses; `digit_valid` = 0; nibble and `dp` unchanged.
- Frame mask:
  - Every written digit, including blank and illegal-pattern writes, sets its mask bit.
  - When the mask becomes 4'b1111, `frame_done` pulses and the mask clears in the same edge.
  - Broadcast therefore completes a frame in one capture.
- Simultaneous events:
  - `clr` together with `err`: `err_sticky` ends set (error wins). The mask clears, then the current capture's bits are applied.
  - Reset mid-dwell discards `cnt` and `prev`; capture restarts from the first post-reset sample.

## Timing
- Latency: if the input changes before edge E1 and stays stable, outputs update on edge E`STABLE_CYCLES`. With the default, the 4th rising edge after the change.
- `err` and `frame_done` are asserted in the same cycle the captured outputs update.
- All outputs are registered; there are no combinational paths from input to output.
- Input glitches shorter than `STABLE_CYCLES` cycles are never captured.

## Structure
- Shared package `ssd_pkg`:
  - The sixteen segment constants (`SS_0`..`SS_F`) and `SS_BLANK`.
  - Select codes `SEL_IDLE` (4'b1111) and `SEL_ALL` (4'b0000).
- One sub-module, `ssd_pattern_to_hex`: combinational 7-bit pattern to `{legal, blank, nibble}`.
- The top level holds the sample register, stability counter, capture logic, per-digit registers and frame mask.

## Test plan
- Reset, then `D`=8'b0000_1101 with `ssd_active`=4'b1110 held 6 cycles → at the 4th edge `value[3:0]`=3, `digit_valid`=4'b0001, `dp`=0; no second capture.
- Scan 1,2,A,F on digits 0..3 with 8 cycles each → `value`=16'hFA21, `digit_valid`=4'hF, `frame_done` pulses once on the digit-3 capture.
- `ssd_active`=4'b0000, `D`=8'b0110_0000 (E, dp lit) → `value`=16'hEEEE, `dp`=4'hF, `frame_done` pulse.
- 3-cycle glitch to 8'b1111_1110 on digit 1, then return to the stable pattern → no capture from the glitch and no `err`. `D`=8'b1010_1010 held → `err` pulse, `err_sticky`=1, `digit_valid[1]`=0.
- `ssd_active`=4'b1100 held → `err` pulse, no digit written. Then `clr` asserted in the same cycle as a new error → `err_sticky` stays 1.
- Assert `rst_n` low during the 3rd cycle of a dwell → all outputs return to reset values immediately. After release, capture occurs `STABLE_CYCLES` edges after the first sample.
